// File: rtl/img_rsz_pkg.sv
// Shared types for the resize divider scheduler: FSM state encoding and
// the colour-index width helper.
package img_rsz_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    OUT
  } DivSchedSt_e;

  // Colour index width; a single-colour pixel still needs a 1-bit index.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CH_IDX_W = ch_idx_w(3);

endpackage

// File: rtl/img_rsz_div_sched.sv
// Shares one multi-cycle divider across all colours of a resized pixel:
// issues one division per colour in order, gathers quotients, emits the pixel.
module img_rsz_div_sched
  import img_rsz_pkg::*;
#(
  parameter int PXL_PRIM_COLOR_NUM  = 3,
  parameter int PXL_PRIM_COLOR_W    = 8,
  parameter int BLK_SUM_MAX_W       = 20,
  parameter int BLK_MAX_SZ_W        = 12,
  parameter int RSZ_IMG_WIDTH_SIZE  = 8,
  parameter int RSZ_IMG_HEIGHT_SIZE = 8
) (
  input  logic                                           Clk,
  input  logic                                           Reset,
  input  logic [PXL_PRIM_COLOR_NUM*BLK_SUM_MAX_W-1:0]    BlkSum,
  input  logic [BLK_MAX_SZ_W-1:0]                        BlkSz,
  input  logic [RSZ_IMG_WIDTH_SIZE-1:0]                  BlkXMsk,
  input  logic [RSZ_IMG_HEIGHT_SIZE-1:0]                 BlkYMsk,
  input  logic                                           BlkVld,
  output logic                                           BlkRdy,
  output logic [BLK_SUM_MAX_W-1:0]                       DivNum,
  output logic [BLK_MAX_SZ_W-1:0]                        DivDen,
  output logic                                           DivBwVld,
  input  logic                                           DivBwRdy,
  input  logic [PXL_PRIM_COLOR_W-1:0]                    DivQuot,
  input  logic                                           DivFwVld,
  output logic                                           DivFwRdy,
  output logic [PXL_PRIM_COLOR_NUM*PXL_PRIM_COLOR_W-1:0] PxlData,
  output logic [RSZ_IMG_WIDTH_SIZE-1:0]                  PxlXMsk,
  output logic [RSZ_IMG_HEIGHT_SIZE-1:0]                 PxlYMsk,
  output logic                                           PxlVld,
  input  logic                                           PxlRdy,
  output logic                                           DivZeroErr
);

  localparam int N  = PXL_PRIM_COLOR_NUM;
  localparam int CW = ch_idx_w(N);
  localparam logic [CW-1:0] LAST_CH = CW'(N - 1);

  DivSchedSt_e                            state_q, state_d;
  logic [CW-1:0]                          ch_q, ch_d;
  logic [N-1:0][BLK_SUM_MAX_W-1:0]        sum_q, sum_d;
  logic [BLK_MAX_SZ_W-1:0]                sz_q, sz_d;
  logic [N-1:0][PXL_PRIM_COLOR_W-1:0]     quot_q, quot_d;
  logic [RSZ_IMG_WIDTH_SIZE-1:0]          xmsk_q, xmsk_d;
  logic [RSZ_IMG_HEIGHT_SIZE-1:0]         ymsk_q, ymsk_d;
  logic                                   err_q, err_d;
  logic                                   acc;

  // OUT can hand off straight to the next block, so no bubble between pixels.
  assign BlkRdy = (state_q == IDLE) | ((state_q == OUT) & PxlRdy);

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    sum_d   = sum_q;
    sz_d    = sz_q;
    quot_d  = quot_q;
    xmsk_d  = xmsk_q;
    ymsk_d  = ymsk_q;
    err_d   = err_q;
    acc     = BlkVld & BlkRdy;

    case (state_q)
      ISSUE: if (DivBwRdy) state_d = WAIT;
      WAIT: begin
        if (DivFwVld) begin
          quot_d[ch_q] = DivQuot;
          if (ch_q == LAST_CH) begin
            state_d = OUT;
          end else begin
            ch_d    = ch_q + CW'(1);
            state_d = ISSUE;
          end
        end
      end
      OUT:     if (PxlRdy) state_d = IDLE;
      default: ;
    endcase

    if (acc) begin
      sum_d  = BlkSum;
      sz_d   = BlkSz;
      xmsk_d = BlkXMsk;
      ymsk_d = BlkYMsk;
      ch_d   = '0;
      if (BlkSz != '0) begin
        state_d = ISSUE;
      end else begin
        // Zero-size block saturates every colour and never reaches the divider.
        quot_d  = '1;
        err_d   = 1'b1;
        state_d = OUT;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      ch_q    <= '0;
      sum_q   <= '0;
      sz_q    <= '0;
      quot_q  <= '0;
      xmsk_q  <= '0;
      ymsk_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      sum_q   <= sum_d;
      sz_q    <= sz_d;
      quot_q  <= quot_d;
      xmsk_q  <= xmsk_d;
      ymsk_q  <= ymsk_d;
      err_q   <= err_d;
    end
  end

  assign DivBwVld   = (state_q == ISSUE);
  assign DivNum     = sum_q[ch_q];
  assign DivDen     = sz_q;
  assign DivFwRdy   = (state_q == WAIT);
  assign PxlVld     = (state_q == OUT);
  assign PxlData    = quot_q;
  assign PxlXMsk    = xmsk_q;
  assign PxlYMsk    = ymsk_q;
  assign DivZeroErr = err_q;

endmodule

// File: tb/tb_img_rsz_div_sched.sv
// Directed bench for img_rsz_div_sched with an in-order divider model of
// programmable latency and request stalls.
module tb_img_rsz_div_sched;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [59:0] BlkSum = '0;
  logic [11:0] BlkSz = '0;
  logic [7:0]  BlkXMsk = '0, BlkYMsk = '0;
  logic        BlkVld = 1'b0;
  logic        BlkRdy;
  logic [19:0] DivNum;
  logic [11:0] DivDen;
  logic        DivBwVld;
  logic        DivBwRdy = 1'b1;
  logic [7:0]  DivQuot = '0;
  logic        DivFwVld = 1'b0;
  logic        DivFwRdy;
  logic [23:0] PxlData;
  logic [7:0]  PxlXMsk, PxlYMsk;
  logic        PxlVld;
  logic        PxlRdy = 1'b1;
  logic        DivZeroErr;

  img_rsz_div_sched dut (
    .Clk(Clk), .Reset(Reset),
    .BlkSum(BlkSum), .BlkSz(BlkSz), .BlkXMsk(BlkXMsk), .BlkYMsk(BlkYMsk),
    .BlkVld(BlkVld), .BlkRdy(BlkRdy),
    .DivNum(DivNum), .DivDen(DivDen), .DivBwVld(DivBwVld), .DivBwRdy(DivBwRdy),
    .DivQuot(DivQuot), .DivFwVld(DivFwVld), .DivFwRdy(DivFwRdy),
    .PxlData(PxlData), .PxlXMsk(PxlXMsk), .PxlYMsk(PxlYMsk),
    .PxlVld(PxlVld), .PxlRdy(PxlRdy), .DivZeroErr(DivZeroErr)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Divider model: one outstanding request, quotient valid L cycles after accept.
  int          L = 3;
  int          stall_left = 0;
  int          req_cnt = 0;
  int          exp_sum [3];
  int          exp_sz = 0;
  logic        busy = 1'b0, bw_hs = 1'b0, fw_hs = 1'b0;
  int          dcnt = 0;
  logic [19:0] qn = '0;
  logic [11:0] qd = 12'd1;

  always begin
    @(negedge Clk);
    #1;
    if (Reset) begin
      busy = 1'b0; DivFwVld = 1'b0; DivBwRdy = 1'b1; bw_hs = 1'b0; fw_hs = 1'b0;
    end else begin
      if (fw_hs) busy = 1'b0;
      if (bw_hs) begin
        busy = 1'b1; dcnt = L - 1; req_cnt++;
      end else if (busy && dcnt > 0) begin
        dcnt--;
      end
      DivFwVld = busy && (dcnt == 0);
      DivQuot  = busy ? 8'(qn / qd) : 8'h00;
      if (DivBwVld && stall_left > 0) begin
        DivBwRdy = 1'b0; stall_left--;
      end else begin
        DivBwRdy = 1'b1;
      end
      if (DivBwVld) begin
        chk("div_num", 64'(DivNum), (req_cnt < 3) ? 64'(exp_sum[req_cnt]) : 64'hDEAD);
        chk("div_den", 64'(DivDen), 64'(exp_sz));
      end
      bw_hs = DivBwVld & DivBwRdy;
      if (bw_hs) begin qn = DivNum; qd = DivDen; end
      fw_hs = DivFwVld & DivFwRdy;
    end
  end

  // Called at a negedge; returns at the negedge after the handshake cycle.
  task automatic send_blk(input int s0, input int s1, input int s2, input int sz,
                          input logic [7:0] x, input logic [7:0] y, output int t);
    bit ok = 0;
    exp_sum[0] = s0; exp_sum[1] = s1; exp_sum[2] = s2; exp_sz = sz; req_cnt = 0;
    BlkSum = {20'(s2), 20'(s1), 20'(s0)};
    BlkSz = 12'(sz); BlkXMsk = x; BlkYMsk = y; BlkVld = 1'b1;
    t = 0;
    for (int k = 0; k < 50; k++) begin
      #1;
      if (BlkRdy) begin ok = 1; t = cyc; break; end
      @(negedge Clk);
    end
    if (!ok) chk("blk_accept_timeout", 0, 1);
    @(negedge Clk);
    BlkVld = 1'b0;
  endtask

  task automatic wait_pxl(output int pc);
    bit ok = 0;
    pc = 0;
    for (int k = 0; k < 200; k++) begin
      if (PxlVld) begin ok = 1; pc = cyc; break; end
      @(negedge Clk);
    end
    if (!ok) chk("pxl_timeout", 0, 1);
  endtask

  int t, pc, npv;
  bit hit;

  initial begin
    // Reset state
    repeat (3) @(negedge Clk);
    chk("rst_pxlvld", PxlVld, 0);
    chk("rst_bwvld", DivBwVld, 0);
    chk("rst_fwrdy", DivFwRdy, 0);
    chk("rst_err", DivZeroErr, 0);
    chk("rst_data", PxlData, 0);
    chk("rst_xmsk", PxlXMsk, 0);
    chk("rst_ymsk", PxlYMsk, 0);
    Reset = 1'b0;
    @(negedge Clk);
    #1 chk("rst_blkrdy", BlkRdy, 1);
    @(negedge Clk);

    // Basic: {300,600,900}/4, L=3
    L = 3;
    send_blk(300, 600, 900, 4, 8'h04, 8'h01, t);
    wait_pxl(pc);
    chk("basic_lat", pc, t + 13);
    chk("basic_data", PxlData, 24'hE1964B);
    chk("basic_x", PxlXMsk, 8'h04);
    chk("basic_y", PxlYMsk, 8'h01);
    chk("basic_req", req_cnt, 3);
    chk("basic_err", DivZeroErr, 0);
    @(negedge Clk);
    chk("basic_done", PxlVld, 0);

    // Divider stall: 3 refused cycles on colour 0
    L = 2; stall_left = 3;
    send_blk(100, 200, 50, 5, 8'h10, 8'h02, t);
    wait_pxl(pc);
    chk("stall_lat", pc, t + 13);
    chk("stall_data", PxlData, 24'h0A2814);
    chk("stall_req", req_cnt, 3);
    @(negedge Clk);

    // Output backpressure for 5 cycles
    L = 1; PxlRdy = 1'b0;
    send_blk(30, 60, 90, 3, 8'h80, 8'h40, t);
    wait_pxl(pc);
    chk("bp_lat", pc, t + 7);
    for (int i = 0; i < 5; i++) begin
      chk("bp_data", PxlData, 24'h1E140A);
      chk("bp_vld", PxlVld, 1);
      chk("bp_blkrdy", BlkRdy, 0);
      chk("bp_bwvld", DivBwVld, 0);
      @(negedge Clk);
    end
    PxlRdy = 1'b1;
    #1 chk("bp_blkrdy_rel", BlkRdy, 1);
    chk("bp_x", PxlXMsk, 8'h80);
    @(negedge Clk);
    chk("bp_done", PxlVld, 0);
    chk("bp_req", req_cnt, 3);

    // Back-to-back: block B accepted in OUT of block A
    PxlRdy = 1'b0;
    send_blk(44, 88, 132, 4, 8'h01, 8'h01, t);
    wait_pxl(pc);
    chk("b2b_a_data", PxlData, 24'h21160B);
    exp_sum[0] = 8; exp_sum[1] = 16; exp_sum[2] = 24; exp_sz = 8; req_cnt = 0;
    BlkSum = {20'd24, 20'd16, 20'd8}; BlkSz = 12'd8; BlkXMsk = 8'h02; BlkYMsk = 8'h04;
    BlkVld = 1'b1; PxlRdy = 1'b1;
    #1 chk("b2b_blkrdy", BlkRdy, 1);
    t = cyc;
    @(negedge Clk);
    BlkVld = 1'b0;
    chk("b2b_issue", DivBwVld, 1);
    chk("b2b_pxl_gone", PxlVld, 0);
    wait_pxl(pc);
    chk("b2b_lat", pc, t + 7);
    chk("b2b_data", PxlData, 24'h030201);
    chk("b2b_x", PxlXMsk, 8'h02);
    chk("b2b_y", PxlYMsk, 8'h04);
    @(negedge Clk);

    // Zero-size block
    send_blk(1, 2, 3, 0, 8'h01, 8'h80, t);
    wait_pxl(pc);
    chk("zero_lat", pc, t + 1);
    chk("zero_data", PxlData, 24'hFFFFFF);
    chk("zero_err", DivZeroErr, 1);
    chk("zero_y", PxlYMsk, 8'h80);
    @(negedge Clk);
    chk("zero_req", req_cnt, 0);
    chk("zero_done", PxlVld, 0);

    // Reset while waiting on colour 1's quotient
    L = 3;
    send_blk(300, 600, 900, 4, 8'h08, 8'h08, t);
    chk("err_sticky", DivZeroErr, 1);
    hit = 0;
    for (int k = 0; k < 50; k++) begin
      if (DivFwRdy && req_cnt == 2) begin hit = 1; break; end
      @(negedge Clk);
    end
    chk("rst_reach_wait1", hit, 1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    chk("mid_rst_pxlvld", PxlVld, 0);
    chk("mid_rst_blkrdy", BlkRdy, 1);
    chk("mid_rst_fwrdy", DivFwRdy, 0);
    chk("mid_rst_err", DivZeroErr, 0);
    npv = 0;
    repeat (20) begin
      @(negedge Clk);
      if (PxlVld || DivBwVld) npv++;
    end
    chk("mid_rst_quiet", npv, 0);
    send_blk(1000, 500, 250, 10, 8'h20, 8'h10, t);
    wait_pxl(pc);
    chk("post_rst_lat", pc, t + 13);
    chk("post_rst_data", PxlData, 24'h193264);
    chk("post_rst_x", PxlXMsk, 8'h20);
    @(negedge Clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
